// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - SPI transaction sequencer framing byte-engine writes and reads under chip select
//
// Ports:
//   clock, rst_n                  clock and asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_tx_len, cmd_rx_len        bytes to write, then bytes to read
//   tx_data/tx_valid/tx_ready     write-byte stream into the sequencer
//   rx_data/rx_valid/rx_ready     read-byte stream out of the sequencer
//   done_o                        one-cycle pulse when a command finishes
//   spi_csn                       chip select to the byte engine, active low
//   wr_en_o, wr_data_o, rd_en_o   registered one-cycle strobes to the byte engine
//   rd_data_i, busy_i             byte engine read data and busy
module spi_xfer_sequencer #(
    parameter int LEN_W    = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_tx_len,
    input  logic [LEN_W-1:0] cmd_rx_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             done_o,
    output logic             spi_csn,
    output logic             wr_en_o,
    output logic [7:0]       wr_data_o,
    output logic             rd_en_o,
    input  logic [7:0]       rd_data_i,
    input  logic             busy_i
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SETUP   = 4'd1;
    localparam logic [3:0] TX_REQ  = 4'd2;
    localparam logic [3:0] TX_WAIT = 4'd3;
    localparam logic [3:0] RX_REQ  = 4'd4;
    localparam logic [3:0] RX_WAIT = 4'd5;
    localparam logic [3:0] RX_PUSH = 4'd6;
    localparam logic [3:0] HOLD    = 4'd7;
    localparam logic [3:0] GAP     = 4'd8;

    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
    localparam logic [LEN_W-1:0] SETUP_CNT = LEN_W'(CS_SETUP);
    localparam logic [LEN_W-1:0] HOLD_CNT  = LEN_W'(CS_HOLD);
    localparam logic [LEN_W-1:0] IDLE_CNT  = LEN_W'(CS_IDLE);

    logic [3:0]       state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] tx_len;
    logic [LEN_W-1:0] rx_len;
    logic             seen_busy;
    logic             xfer_end;

    // Never offer a byte while the engine is still shifting the previous one.
    assign tx_ready = (state == TX_REQ) && !busy_i;

    // The engine raises busy one cycle after the strobe, so a byte is only
    // finished once busy has been seen high and has dropped again.
    assign xfer_end = seen_busy && !busy_i;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_len    <= '0;
            rx_len    <= '0;
            seen_busy <= 1'b0;
            cmd_ready <= 1'b0;
            spi_csn   <= 1'b1;
            wr_en_o   <= 1'b0;
            wr_data_o <= 8'h00;
            rd_en_o   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            rd_en_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        tx_len <= cmd_tx_len;
                        rx_len <= cmd_rx_len;
                        if (cmd_tx_len == '0 && cmd_rx_len == '0) begin
                            // Empty command: finish without touching chip select.
                            done_o <= 1'b1;
                        end else begin
                            spi_csn   <= 1'b0;
                            cnt       <= SETUP_CNT;
                            cmd_ready <= 1'b0;
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt <= ONE) begin
                        state <= (tx_len != '0) ? TX_REQ : RX_REQ;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                TX_REQ: begin
                    if (tx_valid && tx_ready) begin
                        wr_data_o <= tx_data;
                        wr_en_o   <= 1'b1;
                        seen_busy <= 1'b0;
                        state     <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (busy_i) begin
                        seen_busy <= 1'b1;
                    end
                    if (xfer_end) begin
                        if (tx_len != '0) begin
                            tx_len <= tx_len - ONE;
                        end
                        if (tx_len > ONE) begin
                            state <= TX_REQ;
                        end else if (rx_len != '0) begin
                            state <= RX_REQ;
                        end else begin
                            cnt   <= HOLD_CNT;
                            state <= HOLD;
                        end
                    end
                end
                RX_REQ: begin
                    rd_en_o   <= 1'b1;
                    seen_busy <= 1'b0;
                    state     <= RX_WAIT;
                end
                RX_WAIT: begin
                    if (busy_i) begin
                        seen_busy <= 1'b1;
                    end
                    if (xfer_end) begin
                        rx_data  <= rd_data_i;
                        rx_valid <= 1'b1;
                        state    <= RX_PUSH;
                    end
                end
                RX_PUSH: begin
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        if (rx_len != '0) begin
                            rx_len <= rx_len - ONE;
                        end
                        if (rx_len > ONE) begin
                            state <= RX_REQ;
                        end else begin
                            cnt   <= HOLD_CNT;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt <= ONE) begin
                        spi_csn <= 1'b1;
                        done_o  <= 1'b1;
                        cnt     <= IDLE_CNT;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                GAP: begin
                    if (cnt <= ONE) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    spi_csn   <= 1'b1;
                    cmd_ready <= 1'b0;
                    rx_valid  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Transaction sequencer upstream of the SPI byte engine: accepts a command (write-byte count, read-byte count), frames it with chip-select, feeds write bytes to the engine one at a time, then clocks in read bytes and streams them out. It owns `spi_csn` and the engine's `rd_en`/`wr_en`/`wr_data` strobes and watches its `busy`, so client logic (flash/ADC/sensor drivers) only deals with byte streams.

## Interface
- `LEN_W`, 8: width of the byte-count fields.
- `CS_SETUP`, 2: clocks `spi_csn` is low before the first strobe (≥1).
- `CS_HOLD`, 2: clocks `spi_csn` stays low after the last byte completes (≥1).
- `CS_IDLE`, 4: minimum clocks `spi_csn` is high between transactions (≥1).

Ports:
- `clock` in 1: single clock; all logic rises on it.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_tx_len` in LEN_W: number of bytes to write (0..2^LEN_W-1).
- `cmd_rx_len` in LEN_W: number of bytes to read after the writes.
- `tx_data` in 8, `tx_valid` in 1, `tx_ready` out 1: write-byte stream.
- `rx_data` out 8, `rx_valid` out 1, `rx_ready` in 1: read-byte stream.
- `done_o` out 1: one-cycle pulse when a command finishes.
- `spi_csn` out 1: chip select to the engine, active low.
- `wr_en_o` out 1, `wr_data_o` out 8, `rd_en_o` out 1: engine strobes.
- `rd_data_i` in 8, `busy_i` in 1: engine read data and busy.

## Operation
- States: IDLE, SETUP, TX_REQ, TX_WAIT, RX_REQ, RX_WAIT, RX_PUSH, HOLD, GAP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch both lengths.
  - If both lengths are 0: pulse `done_o` the next cycle, leave `spi_csn` high, and stay in IDLE.
  - Otherwise: drive `spi_csn` low, load a counter with CS_SETUP, and go to SETUP.
- SETUP: count down. Then go to TX_REQ if tx_len>0, else RX_REQ.
- TX_REQ:
  - `tx_ready`=1 only in this state and only while `busy_i`=0.
  - On a tx handshake, register `wr_data_o`=`tx_data` and `wr_en_o`=1 for exactly the next cycle, then go to TX_WAIT.
- TX_WAIT:
  - Set the `seen_busy` flag when `busy_i`=1.
  - When `seen_busy`=1 and `busy_i`=0: decrement tx_len, then go to TX_REQ if more bytes remain, else RX_REQ if rx_len>0, else HOLD.
  - Read data captured during writes is discarded.
- RX_REQ: `rd_en_o`=1 for one cycle (registered). `wr_data_o` holds its last value; the engine shifts zeros. Go to RX_WAIT.
- RX_WAIT: same `seen_busy` rule as TX_WAIT. On completion, register `rx_data`=`rd_data_i` and `rx_valid`=1, then go to RX_PUSH.
- RX_PUSH:
  - Hold `rx_data` and `rx_valid` until `rx_ready`=1.
  - On the handshake, drop `rx_valid` the next cycle, decrement rx_len, and go to RX_REQ if more bytes remain, else HOLD.
  - `spi_csn` stays low for the whole stall.
- HOLD: count CS_HOLD. Then `spi_csn`=1, `done_o` pulses for one cycle, and the state moves to GAP.
- GAP: count CS_IDLE with `cmd_ready`=0. Then go to IDLE.
- `wr_en_o` and `rd_en_o` are never high together. Neither is ever high while `spi_csn`=1.
- Counters are LEN_W wide and never wrap: decrement only when nonzero.

## Timing
- Reset values (async, take effect immediately on `rst_n` fall):
  - `spi_csn`=1, `cmd_ready`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `done_o`=0, `wr_en_o`=0, `rd_en_o`=0, `wr_data_o`=0.
  - State returns to IDLE; `cmd_ready`=1 from the first clock after release.
- Reset mid-transaction aborts it: `spi_csn` rises at once, no `done_o` is issued, and in-flight bytes are lost.
- Command accept to `spi_csn` low: 1 cycle. `spi_csn` low to first strobe: CS_SETUP+1 cycles (includes the TX_REQ handshake cycle).
- Strobe is registered: handshake in cycle N, strobe high in cycle N+1, engine `busy_i` expected from N+2.
- Next strobe is issued no earlier than 2 cycles after `busy_i` is observed low.
- `rx_valid` rises 1 cycle after `busy_i` is observed low. `rx_ready` may be held high; this gives zero stall.
- A `cmd_valid` arriving while not in IDLE is ignored (`cmd_ready`=0). It is accepted the cycle IDLE is entered.
- `tx_valid` low in TX_REQ stalls indefinitely with `spi_csn` low. This is legal.

## Test plan
- Write 2 bytes (0xA5, 0x3C), read 0, engine model busy=17 cycles -> `wr_data_o` sequence A5, 3C; one `wr_en_o` pulse each; `spi_csn` low for the full frame; one `done_o`; no `rx_valid`.
- Write 1 byte (0x9F), read 3, model returns 0xEF, 0x40, 0x18 -> `rx_data` EF, 40, 18 in order; exactly 1 `wr_en_o` and 3 `rd_en_o`.
- Read 2 with `rx_ready` held low for 30 cycles on the first byte -> `rx_valid`/`rx_data` stable; no second `rd_en_o` until the handshake; `spi_csn` low throughout.
- tx_len=0, rx_len=0 -> `done_o` 1 cycle after accept; `spi_csn` never falls.
- Back-to-back commands with `cmd_valid` held high -> `spi_csn` high for ≥CS_IDLE cycles between frames; CS_SETUP/CS_HOLD gaps measured exact.
- Assert `rst_n`=0 during the second of 4 writes -> `spi_csn`=1 asynchronously, strobes 0, no `done_o`; a new command after release completes normally.
